counter_access_arbiter: RTL
===========================

Name: counter_access_arbiter

Overview:
Shares one N-bit saturating up/down counter (load/inc/dec/din in; count/saturated/zeroed out) between NREQ requesters. Arbitration is round-robin, with at most one command accepted per cycle. The block drives the counter's registered command strobes and returns a tagged response carrying the post-update count and a clip flag. It sits between the requester agents and the counter instance.

Parameters:
NREQ, 4, number of requesters; must be >= 2; need not be a power of 2.
N, 8, counter/data width.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
req  input  NREQ  per-requester command request.
req_op  input  2*NREQ  per-requester op, slice [2i+1:2i]: 00 read, 01 inc, 10 dec, 11 load.
req_din  input  N*NREQ  per-requester load data, slice [N*i+N-1:N*i].
gnt  output  NREQ  one-hot acceptance; combinational in the request cycle.
cnt_load  output  1  registered load strobe to counter.
cnt_inc  output  1  registered increment strobe to counter.
cnt_dec  output  1  registered decrement strobe to counter.
cnt_din  output  N  registered load data to counter.
count  input  N  counter value.
saturated  input  1  counter at all-ones.
zeroed  input  1  counter at zero.
rsp_valid  output  1  response valid, one cycle per accepted command.
rsp_id  output  max(1,$clog2(NREQ))  index of the requester that issued the command.
rsp_count  output  N  counter value after the command; equals count while rsp_valid.
rsp_clipped  output  1  inc issued while saturated, or dec issued while zeroed.

Behaviour:
- Reset (async assert): gnt=0, cnt_load/inc/dec=0, cnt_din=0, rsp_valid=0, rsp_id=0, rsp_clipped=0, rr pointer=0, pipeline valid bits cleared. In-flight commands are dropped with no response. gnt is forced to 0 while reset is high.
- Arbitration, cycle T: scan from ptr upward with wrap (ptr, ptr+1 … NREQ-1, 0 … ptr-1). The first set req wins and its gnt bit is high in T. At most one gnt bit is set. If no req is set, gnt=0 and ptr holds.
- Pointer update: after a grant to i, ptr <= (i==NREQ-1) ? 0 : i+1.
- Requester rule: req/op/din are held stable until gnt. A requester may keep req high to issue another command, which is re-arbitrated normally.
- Stage 1, cycle T+1: registered from the winner. cnt_inc=(op==01), cnt_dec=(op==10), cnt_load=(op==11), cnt_din=winner din when load, else 0. At most one strobe is high, and each is high for exactly one cycle per command. op 00 asserts no strobe.
- Clip capture: in T+1, clip = (op==01 & saturated) | (op==10 & zeroed), registered into stage 2.
- Stage 2, cycle T+2: rsp_valid=1, rsp_id=winner index, rsp_clipped=captured clip, rsp_count=count. The counter updated at the T+1→T+2 edge.
- Latency: gnt→strobe is 1 cycle; gnt→rsp_valid is 2 cycles.
- Throughput: one command per cycle, back-to-back, with no bubbles. Responses are returned in grant order.
- rsp_id/rsp_count/rsp_clipped are don't-care when rsp_valid=0.
- This block does not clip; the counter saturates. The block only reports a clip.
- Counter reset is driven externally. If the counter resets while a command is in flight, the response reports whatever count shows.

Test Plan:
- Reset, count=0; req[0] op=01 for 1 cycle -> gnt[0] in T; cnt_inc=1 only in T+1; in T+2 rsp_valid=1, rsp_id=0, rsp_count=1, rsp_clipped=0.
- req[3:0]=1111 held, all op=01, count=0 -> gnt sequence 0,1,2,3,0,1; rsp_count 1,2,3,4,5,6 on consecutive cycles; rsp_id 0,1,2,3,0,1.
- req[2] op=11 din=0xFE, then op=01 twice -> cnt_din=0xFE with cnt_load; responses 0xFE/0, 0xFF/0, 0xFF/clipped=1.
- count=0; req[1] op=10 -> cnt_dec strobed; rsp_count=0x00, rsp_clipped=1, rsp_id=1.
- count=0x42; req[3] op=00 -> no cnt_* strobe; rsp_valid in T+2 with rsp_count=0x42, rsp_clipped=0.
- ptr=2, stage 1 and stage 2 both full; assert reset mid-cycle -> gnt, cnt_* and rsp_valid go 0 immediately; no response after release; then req[3]=req[0]=1 -> gnt[0] first (ptr=0), then gnt[3].

Source files
------------

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter that shares one saturating up/down counter between NREQ requesters.
// Grant is combinational, the counter strobes follow one cycle later, and the tagged response one cycle after that.

module caa_lane #(
  parameter int N = 8
) (
  input  logic         req_i,
  input  logic         at_or_above_ptr_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] din_i,
  output logic         hi_req_o,
  output logic         inc_o,
  output logic         dec_o,
  output logic         load_o,
  output logic [N-1:0] din_o
);
  // The high half of the wrapped scan covers ptr..NREQ-1 and takes precedence over the low half.
  assign hi_req_o = req_i & at_or_above_ptr_i;
  assign inc_o    = (op_i == 2'b01);
  assign dec_o    = (op_i == 2'b10);
  assign load_o   = (op_i == 2'b11);
  assign din_o    = load_o ? din_i : '0;
endmodule

module counter_access_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 8,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [N*NREQ-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic              cnt_load,
  output logic              cnt_inc,
  output logic              cnt_dec,
  output logic [N-1:0]      cnt_din,
  input  logic [N-1:0]      count,
  input  logic              saturated,
  input  logic              zeroed,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_count,
  output logic              rsp_clipped
);
  localparam int STAGES = 2;

  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [NREQ-1:0]         lane_hi, lane_inc, lane_dec, lane_load;
  logic [NREQ-1:0][N-1:0]  lane_din;

  logic                    win_vld;
  logic [IDW-1:0]          win_idx;

  logic [STAGES:1]         vld_pipe_q, vld_pipe_d;
  logic                    cnt_load_q, cnt_load_d;
  logic                    cnt_inc_q, cnt_inc_d;
  logic                    cnt_dec_q, cnt_dec_d;
  logic [N-1:0]            cnt_din_q, cnt_din_d;
  logic [IDW-1:0]          s1_id_q, s1_id_d;
  logic [IDW-1:0]          rsp_id_q, rsp_id_d;
  logic                    rsp_clipped_q, rsp_clipped_d;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    caa_lane #(.N(N)) u_lane (
      .req_i             (req[i]),
      .at_or_above_ptr_i (IDW'(i) >= ptr_q),
      .op_i              (req_op[2*i +: 2]),
      .din_i             (req_din[N*i +: N]),
      .hi_req_o          (lane_hi[i]),
      .inc_o             (lane_inc[i]),
      .dec_o             (lane_dec[i]),
      .load_o            (lane_load[i]),
      .din_o             (lane_din[i])
    );
  end

  // Wrapped scan: lowest index at/above ptr wins, otherwise lowest index overall.
  always_comb begin
    logic found;
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && lane_hi[i]) begin
        found   = 1'b1;
        win_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        win_idx = IDW'(i);
      end
    end
    win_vld = found & ~reset;
  end

  always_comb begin
    gnt = '0;
    if (win_vld) gnt[win_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (win_vld) ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;

    vld_pipe_d[1] = win_vld;
    vld_pipe_d[2] = vld_pipe_q[1];

    cnt_inc_d  = win_vld & lane_inc[win_idx];
    cnt_dec_d  = win_vld & lane_dec[win_idx];
    cnt_load_d = win_vld & lane_load[win_idx];
    cnt_din_d  = win_vld ? lane_din[win_idx] : '0;
    s1_id_d    = win_vld ? win_idx : s1_id_q;

    // Clip is judged against the counter state seen while the strobe is on the wire.
    rsp_id_d      = vld_pipe_q[1] ? s1_id_q : rsp_id_q;
    rsp_clipped_d = (cnt_inc_q & saturated) | (cnt_dec_q & zeroed);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q         <= '0;
      vld_pipe_q    <= '0;
      cnt_load_q    <= 1'b0;
      cnt_inc_q     <= 1'b0;
      cnt_dec_q     <= 1'b0;
      cnt_din_q     <= '0;
      s1_id_q       <= '0;
      rsp_id_q      <= '0;
      rsp_clipped_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      vld_pipe_q    <= vld_pipe_d;
      cnt_load_q    <= cnt_load_d;
      cnt_inc_q     <= cnt_inc_d;
      cnt_dec_q     <= cnt_dec_d;
      cnt_din_q     <= cnt_din_d;
      s1_id_q       <= s1_id_d;
      rsp_id_q      <= rsp_id_d;
      rsp_clipped_q <= rsp_clipped_d;
    end
  end

  assign cnt_load    = cnt_load_q;
  assign cnt_inc     = cnt_inc_q;
  assign cnt_dec     = cnt_dec_q;
  assign cnt_din     = cnt_din_q;
  assign rsp_valid   = vld_pipe_q[STAGES];
  assign rsp_id      = rsp_id_q;
  assign rsp_clipped = rsp_clipped_q;
  assign rsp_count   = count;
endmodule
